ground_anim_seq: RTL and testbench

Parametrised crumble-animation sequencer for breakable ground tiles in the VGA game pipeline. It generates its own frame tick and runs one independent crumble state machine per tile channel. Each channel runs a programmable per-frame hold schedule and an optional respawn phase. A registered pixel mux selects the current frame's ROM pixel for whichever tile the renderer is drawing. It sits between the collision logic (touch flags) and the VGA colour mux, and replaces the per-tile ground display instances.

---
 rtl/ground_anim_seq.sv | 229 ++++++++++++++++++++++
 tb/tb_ground_anim_seq.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ground_anim_seq.sv
// ground_anim_seq
// Crumble-animation sequencer for breakable ground tiles. A shared divider
// produces the animation tick; each tile channel walks frames 0..3 on a
// programmable hold schedule after being touched, optionally respawning.
// A registered mux picks the ROM pixel for the tile being drawn.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   touched      per-tile touch flag (level)
//   tile_sel     tile currently being drawn by the renderer
//   pix_f0..3    frame-ROM pixel (RGB444) for frames 0..3
//   vga_pix      selected pixel, registered (12'h000 for out-of-range tile_sel)
//   frame_idx    per-tile current frame, tile i at [2i+1:2i]
//   solid        1 = tile collidable
//   broken_pulse one-cycle strobe when a tile becomes broken
//   tick         animation tick strobe
module ground_anim_seq #(
  parameter int N_TILES       = 3,
  parameter int TICK_DIV      = 6000000,
  parameter int HOLD0         = 15,
  parameter int HOLD1         = 3,
  parameter int HOLD2         = 4,
  parameter int RESPAWN_TICKS = 0
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic [N_TILES-1:0]                            touched,
  input  logic [((N_TILES > 1) ? $clog2(N_TILES) : 1)-1:0] tile_sel,
  input  logic [11:0]                                   pix_f0,
  input  logic [11:0]                                   pix_f1,
  input  logic [11:0]                                   pix_f2,
  input  logic [11:0]                                   pix_f3,
  output logic [11:0]                                   vga_pix,
  output logic [2*N_TILES-1:0]                          frame_idx,
  output logic [N_TILES-1:0]                            solid,
  output logic [N_TILES-1:0]                            broken_pulse,
  output logic                                          tick
);

  localparam int SW = (N_TILES > 1) ? $clog2(N_TILES) : 1;
  localparam int TW = $clog2(TICK_DIV);

  // hold counter must cover the longest hold or respawn interval, min 5 bits
  localparam int HMAX_A = (HOLD0 > HOLD1) ? HOLD0 : HOLD1;
  localparam int HMAX_B = (HOLD2 > RESPAWN_TICKS) ? HOLD2 : RESPAWN_TICKS;
  localparam int HMAX   = (HMAX_A > HMAX_B) ? HMAX_A : HMAX_B;
  localparam int HW_RAW = $clog2(HMAX + 1);
  localparam int HW     = (HW_RAW < 5) ? 5 : HW_RAW;

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [TW-1:0] TICK_PRE  = TW'(TICK_DIV - 2);
  localparam logic [HW-1:0] H0_LAST   = HW'(HOLD0 - 1);
  localparam logic [HW-1:0] H1_LAST   = HW'(HOLD1 - 1);
  localparam logic [HW-1:0] H2_LAST   = HW'(HOLD2 - 1);
  localparam logic [HW-1:0] RSP_LAST  = HW'((RESPAWN_TICKS > 0) ? (RESPAWN_TICKS - 1) : 0);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CRUMBLE = 2'd1,
    ST_BROKEN  = 2'd2,
    ST_RESPAWN = 2'd3
  } state_t;

  logic [TW-1:0] tick_cnt_r;
  logic          tick_r;
  logic [11:0]   vga_pix_r;
  logic [1:0]    sel_frame_s;
  logic          sel_hit_s;
  logic [11:0]   pix_s;

  // Tick divider; tick_r is set one cycle early so it is high exactly while
  // tick_cnt_r sits at its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_r <= {TW{1'b0}};
      tick_r     <= 1'b0;
    end else begin
      tick_cnt_r <= (tick_cnt_r == TICK_LAST) ? {TW{1'b0}} : (tick_cnt_r + TW'(1));
      tick_r     <= (tick_cnt_r == TICK_PRE);
    end
  end

  assign tick = tick_r;

  for (genvar g = 0; g < N_TILES; g++) begin : g_ch
    state_t        state_r, state_s;
    logic [1:0]    frame_r, frame_s;
    logic [HW-1:0] hold_r, hold_s, hold_last_s;
    logic          solid_r, solid_s;
    logic          pulse_r, pulse_s;

    // Channel next-state: frame schedule, solid flag and broken strobe.
    always_comb begin
      state_s     = state_r;
      frame_s     = frame_r;
      hold_s      = hold_r;
      solid_s     = solid_r;
      pulse_s     = 1'b0;
      case (frame_r)
        2'd1:    hold_last_s = H1_LAST;
        2'd2:    hold_last_s = H2_LAST;
        default: hold_last_s = H0_LAST;
      endcase
      case (state_r)
        ST_IDLE: begin
          frame_s = 2'd0;
          solid_s = 1'b1;
          hold_s  = {HW{1'b0}};
          // a tick coinciding with the touch is not counted
          if (touched[g]) begin
            state_s = ST_CRUMBLE;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_CRUMBLE: begin
          if (tick_r) begin
            if (hold_r == hold_last_s) begin
              hold_s = {HW{1'b0}};
              if (frame_r == 2'd2) begin
                state_s = ST_BROKEN;
                frame_s = 2'd3;
                solid_s = 1'b0;
                pulse_s = 1'b1;
              end else begin
                frame_s = frame_r + 2'd1;
              end
            end else begin
              hold_s = hold_r + HOLD_ONE;
            end
          end else begin
            hold_s = hold_r;
          end
        end
        ST_BROKEN: begin
          frame_s = 2'd3;
          solid_s = 1'b0;
          // without a respawn interval the tile stays broken until reset
          if (RESPAWN_TICKS != 0) begin
            state_s = ST_RESPAWN;
            hold_s  = {HW{1'b0}};
          end else begin
            state_s = ST_BROKEN;
          end
        end
        ST_RESPAWN: begin
          if (tick_r) begin
            if (hold_r == RSP_LAST) begin
              state_s = ST_IDLE;
              frame_s = 2'd0;
              solid_s = 1'b1;
              hold_s  = {HW{1'b0}};
            end else begin
              hold_s = hold_r + HOLD_ONE;
            end
          end else begin
            hold_s = hold_r;
          end
        end
        default: begin
          state_s = ST_IDLE;
          frame_s = 2'd0;
          solid_s = 1'b1;
          hold_s  = {HW{1'b0}};
        end
      endcase
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_r <= ST_IDLE;
        frame_r <= 2'd0;
        hold_r  <= {HW{1'b0}};
        solid_r <= 1'b1;
        pulse_r <= 1'b0;
      end else begin
        state_r <= state_s;
        frame_r <= frame_s;
        hold_r  <= hold_s;
        solid_r <= solid_s;
        pulse_r <= pulse_s;
      end
    end

    assign frame_idx[2*g +: 2] = frame_r;
    assign solid[g]            = solid_r;
    assign broken_pulse[g]     = pulse_r;
  end

  // Pixel select from the registered frame of the selected tile (no bypass).
  always_comb begin
    sel_frame_s = 2'd0;
    sel_hit_s   = 1'b0;
    for (int i = 0; i < N_TILES; i++) begin
      if (tile_sel == SW'(i)) begin
        sel_frame_s = frame_idx[2*i +: 2];
        sel_hit_s   = 1'b1;
      end else begin
        sel_hit_s   = sel_hit_s;
      end
    end
    case (sel_frame_s)
      2'd0:    pix_s = pix_f0;
      2'd1:    pix_s = pix_f1;
      2'd2:    pix_s = pix_f2;
      default: pix_s = pix_f3;
    endcase
    if (!sel_hit_s) begin
      pix_s = 12'h000;
    end else begin
      pix_s = pix_s;
    end
  end

  // Output pixel register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_pix_r <= 12'h000;
    end else begin
      vga_pix_r <= pix_s;
    end
  end

  assign vga_pix = vga_pix_r;

endmodule

// File: tb/tb_ground_anim_seq.sv
// Scoreboard bench for ground_anim_seq: two instances (no respawn / respawn
// after 10 ticks), TICK_DIV=4, holds 15/3/4. Expected output changes and
// timed samples are queued by the stimulus; monitors compare on negedge.
module tb_ground_anim_seq;

  typedef struct {
    int         cyc;
    logic [5:0] fi;
    logic [2:0] sol;
    logic [2:0] bp;
  } chg_t;

  typedef struct {
    int          cyc;
    logic [11:0] val;
  } tim_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rsp_rst_n = 1'b0;
  logic [2:0]  touched = 3'b000;
  logic [2:0]  rsp_touched = 3'b000;
  logic [1:0]  tile_sel = 2'd0;
  logic [1:0]  rsp_tile_sel = 2'd0;
  logic [11:0] pix_f0 = 12'h000;
  logic [11:0] pix_f1 = 12'h000;
  logic [11:0] pix_f2 = 12'h000;
  logic [11:0] pix_f3 = 12'h000;

  logic [11:0] vga_pix, rsp_vga_pix;
  logic [5:0]  frame_idx, rsp_frame_idx;
  logic [2:0]  solid, rsp_solid;
  logic [2:0]  broken_pulse, rsp_broken_pulse;
  logic        tick, rsp_tick;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int rsp_cyc = 0;

  chg_t chg_q[$], rsp_chg_q[$];
  tim_t tick_q[$], rsp_tick_q[$], pix_q[$], rsp_pix_q[$];
  logic [11:0] prev_main, prev_rsp;
  chg_t ce_main, ce_rsp;
  tim_t te_main, te_rsp, pe_main, pe_rsp;

  ground_anim_seq #(.N_TILES(3), .TICK_DIV(4), .HOLD0(15), .HOLD1(3), .HOLD2(4),
                    .RESPAWN_TICKS(0)) dut (
    .clk(clk), .rst_n(rst_n), .touched(touched), .tile_sel(tile_sel),
    .pix_f0(pix_f0), .pix_f1(pix_f1), .pix_f2(pix_f2), .pix_f3(pix_f3),
    .vga_pix(vga_pix), .frame_idx(frame_idx), .solid(solid),
    .broken_pulse(broken_pulse), .tick(tick)
  );

  ground_anim_seq #(.N_TILES(3), .TICK_DIV(4), .HOLD0(15), .HOLD1(3), .HOLD2(4),
                    .RESPAWN_TICKS(10)) dut_rsp (
    .clk(clk), .rst_n(rsp_rst_n), .touched(rsp_touched), .tile_sel(rsp_tile_sel),
    .pix_f0(pix_f0), .pix_f1(pix_f1), .pix_f2(pix_f2), .pix_f3(pix_f3),
    .vga_pix(rsp_vga_pix), .frame_idx(rsp_frame_idx), .solid(rsp_solid),
    .broken_pulse(rsp_broken_pulse), .tick(rsp_tick)
  );

  always #5 clk = ~clk;

  // cycle counters: edge n after reset release -> counter n
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(posedge clk or negedge rsp_rst_n) begin
    if (!rsp_rst_n) rsp_cyc <= 0;
    else            rsp_cyc <= rsp_cyc + 1;
  end

  task automatic chk(input string name, input bit ok, input string msg);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: %s", name, msg);
    end
  endtask

  // monitor for the no-respawn instance
  always @(negedge clk) begin
    if ({frame_idx, solid, broken_pulse} !== prev_main) begin
      prev_main = {frame_idx, solid, broken_pulse};
      if (chg_q.size() == 0) begin
        chk("main_unexpected", 1'b0, $sformatf("cyc %0d got fi=%b solid=%b bp=%b, required no change",
            cyc, frame_idx, solid, broken_pulse));
      end else begin
        ce_main = chg_q.pop_front();
        chk("main_event", (ce_main.cyc == cyc) && (frame_idx === ce_main.fi) &&
            (solid === ce_main.sol) && (broken_pulse === ce_main.bp),
            $sformatf("got cyc %0d fi=%b solid=%b bp=%b, required cyc %0d fi=%b solid=%b bp=%b",
            cyc, frame_idx, solid, broken_pulse, ce_main.cyc, ce_main.fi, ce_main.sol, ce_main.bp));
      end
    end
    if (tick_q.size() != 0 && tick_q[0].cyc <= cyc) begin
      te_main = tick_q.pop_front();
      chk("main_tick", (te_main.cyc == cyc) && (tick === te_main.val[0]),
          $sformatf("cyc %0d got tick=%b, required cyc %0d tick=%b", cyc, tick, te_main.cyc, te_main.val[0]));
    end
    if (pix_q.size() != 0 && pix_q[0].cyc <= cyc) begin
      pe_main = pix_q.pop_front();
      chk("main_pix", (pe_main.cyc == cyc) && (vga_pix === pe_main.val),
          $sformatf("cyc %0d got vga_pix=%h, required cyc %0d vga_pix=%h", cyc, vga_pix, pe_main.cyc, pe_main.val));
    end
  end

  // monitor for the respawn instance
  always @(negedge clk) begin
    if ({rsp_frame_idx, rsp_solid, rsp_broken_pulse} !== prev_rsp) begin
      prev_rsp = {rsp_frame_idx, rsp_solid, rsp_broken_pulse};
      if (rsp_chg_q.size() == 0) begin
        chk("rsp_unexpected", 1'b0, $sformatf("cyc %0d got fi=%b solid=%b bp=%b, required no change",
            rsp_cyc, rsp_frame_idx, rsp_solid, rsp_broken_pulse));
      end else begin
        ce_rsp = rsp_chg_q.pop_front();
        chk("rsp_event", (ce_rsp.cyc == rsp_cyc) && (rsp_frame_idx === ce_rsp.fi) &&
            (rsp_solid === ce_rsp.sol) && (rsp_broken_pulse === ce_rsp.bp),
            $sformatf("got cyc %0d fi=%b solid=%b bp=%b, required cyc %0d fi=%b solid=%b bp=%b",
            rsp_cyc, rsp_frame_idx, rsp_solid, rsp_broken_pulse, ce_rsp.cyc, ce_rsp.fi, ce_rsp.sol, ce_rsp.bp));
      end
    end
    if (rsp_tick_q.size() != 0 && rsp_tick_q[0].cyc <= rsp_cyc) begin
      te_rsp = rsp_tick_q.pop_front();
      chk("rsp_tick", (te_rsp.cyc == rsp_cyc) && (rsp_tick === te_rsp.val[0]),
          $sformatf("cyc %0d got tick=%b, required cyc %0d tick=%b", rsp_cyc, rsp_tick, te_rsp.cyc, te_rsp.val[0]));
    end
    if (rsp_pix_q.size() != 0 && rsp_pix_q[0].cyc <= rsp_cyc) begin
      pe_rsp = rsp_pix_q.pop_front();
      chk("rsp_pix", (pe_rsp.cyc == rsp_cyc) && (rsp_vga_pix === pe_rsp.val),
          $sformatf("cyc %0d got vga_pix=%h, required cyc %0d vga_pix=%h", rsp_cyc, rsp_vga_pix, pe_rsp.cyc, pe_rsp.val));
    end
  end

  task automatic wait_main(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_rsp(input int c);
    while (rsp_cyc < c) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic main_seq();
    chg_q.push_back('{0, 6'b000000, 3'b111, 3'b000});
    tick_q.push_back('{0, 12'h000});
    pix_q.push_back('{0, 12'h000});
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    tick_q.push_back('{2, 12'h000});
    tick_q.push_back('{3, 12'h001});
    tick_q.push_back('{4, 12'h000});
    tick_q.push_back('{7, 12'h001});
    tick_q.push_back('{11, 12'h001});
    // single 1-cycle touch on tile 0, entry at edge 13
    wait_main(12);
    touched = 3'b001;
    chg_q.push_back('{72,  6'b000001, 3'b111, 3'b000});
    chg_q.push_back('{84,  6'b000010, 3'b111, 3'b000});
    chg_q.push_back('{100, 6'b000011, 3'b110, 3'b001});
    chg_q.push_back('{101, 6'b000011, 3'b110, 3'b000});
    wait_main(13);
    touched = 3'b000;
    // tiles 1 and 2 together, tile 1 released after 2 ticks
    wait_main(104);
    touched = 3'b110;
    chg_q.push_back('{164, 6'b010111, 3'b110, 3'b000});
    chg_q.push_back('{176, 6'b101011, 3'b110, 3'b000});
    chg_q.push_back('{192, 6'b111111, 3'b000, 3'b110});
    chg_q.push_back('{193, 6'b111111, 3'b000, 3'b000});
    wait_main(112);
    touched = 3'b100;
    // pixel mux; edge 176 still sees tile 1 at frame 1
    wait_main(175);
    pix_f0 = 12'h111;
    pix_f1 = 12'h222;
    pix_f2 = 12'hABC;
    pix_f3 = 12'h333;
    tile_sel = 2'd1;
    pix_q.push_back('{176, 12'h222});
    pix_q.push_back('{177, 12'hABC});
    wait_main(177);
    tile_sel = 2'd3;
    pix_q.push_back('{178, 12'h000});
    wait_main(178);
    tile_sel = 2'd0;
    pix_q.push_back('{179, 12'h333});
    wait_main(179);
    tile_sel = 2'd2;
    pix_q.push_back('{180, 12'hABC});
    wait_main(200);
  endtask

  task automatic rsp_seq();
    rsp_chg_q.push_back('{0, 6'b000000, 3'b111, 3'b000});
    rsp_tick_q.push_back('{0, 12'h000});
    rsp_pix_q.push_back('{0, 12'h000});
    repeat (3) @(posedge clk);
    #2 rsp_rst_n = 1'b1;
    rsp_tick_q.push_back('{3, 12'h001});
    rsp_tick_q.push_back('{4, 12'h000});
    // tile 1 touched and held: crumble, break, respawn, re-trigger
    wait_rsp(12);
    rsp_touched = 3'b010;
    rsp_chg_q.push_back('{72,  6'b000100, 3'b111, 3'b000});
    rsp_chg_q.push_back('{84,  6'b001000, 3'b111, 3'b000});
    rsp_chg_q.push_back('{100, 6'b001100, 3'b101, 3'b010});
    rsp_chg_q.push_back('{101, 6'b001100, 3'b101, 3'b000});
    rsp_chg_q.push_back('{140, 6'b000000, 3'b111, 3'b000});
    rsp_chg_q.push_back('{200, 6'b000100, 3'b111, 3'b000});
    rsp_chg_q.push_back('{212, 6'b001000, 3'b111, 3'b000});
    wait_rsp(211);
    rsp_tile_sel = 2'd1;
    rsp_pix_q.push_back('{212, 12'h222});
    rsp_pix_q.push_back('{213, 12'hABC});
    // asynchronous reset between edges while tile 1 is at frame 2
    wait_rsp(214);
    rsp_rst_n = 1'b0;
    rsp_touched = 3'b000;
    rsp_chg_q.push_back('{0, 6'b000000, 3'b111, 3'b000});
    rsp_pix_q.push_back('{0, 12'h000});
    repeat (2) @(posedge clk);
    #2 rsp_rst_n = 1'b1;
    wait_rsp(80);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    fork
      main_seq();
      rsp_seq();
    join
    repeat (2) @(negedge clk);
    #1;
    chk("main_chg_drain", chg_q.size() == 0, $sformatf("got %0d pending, required 0", chg_q.size()));
    chk("main_tick_drain", tick_q.size() == 0, $sformatf("got %0d pending, required 0", tick_q.size()));
    chk("main_pix_drain", pix_q.size() == 0, $sformatf("got %0d pending, required 0", pix_q.size()));
    chk("rsp_chg_drain", rsp_chg_q.size() == 0, $sformatf("got %0d pending, required 0", rsp_chg_q.size()));
    chk("rsp_tick_drain", rsp_tick_q.size() == 0, $sformatf("got %0d pending, required 0", rsp_tick_q.size()));
    chk("rsp_pix_drain", rsp_pix_q.size() == 0, $sformatf("got %0d pending, required 0", rsp_pix_q.size()));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
